stage_if: RTL and testbench



---
 rtl/stage_if_pkg.sv | 13 +
 rtl/stage_if_imem.sv | 16 +
 rtl/stage_if.sv | 92 +++++++++
 tb/tb_stage_if.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared pipeline definitions: instruction width, bubble/halt encodings and fetch FSM states.
package stage_if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000000;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } if_state_e;

endpackage

// File: rtl/stage_if_imem.sv
// Word-addressed instruction ROM with combinational read; contents are written by the environment.
module InstructionMemory
  import stage_if_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic [AW-1:0]      addr,
  output logic [INSTR_W-1:0] data
);

  logic [INSTR_W-1:0] mem [IMEM_DEPTH];

  assign data = mem[addr];

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC register, RUN/HALTED FSM and IF/ID pipeline register.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter logic [31:0] NOP_INSTR   = stage_if_pkg::NOP_INSTR,
  parameter logic [5:0]  HALT_OPCODE = stage_if_pkg::HALT_OPCODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic [31:0] instr,
  output logic [31:0] pcPlus4,
  output logic        valid,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] fetched;
  logic [31:0]        pc_inc;

  InstructionMemory #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
    .addr (pc_q[AW+1:2]),
    .data (fetched)
  );

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (branchTaken) begin
      // Redirect wins over stall and discards whatever was fetched this cycle.
      pc_d    = branchTarget & 32'hFFFF_FFFC;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == HALTED) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d    = fetched;
      pc_plus4_d = pc_inc;
      valid_d    = 1'b1;
      if (fetched[31:26] == HALT_OPCODE) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr   = instr_q;
  assign pcPlus4 = pc_plus4_q;
  assign valid   = valid_q;
  assign halted  = (state_q == HALTED);
  assign pc      = pc_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: fetch, stall, branch, halt, reset override and address wrap.
module tb_stage_if;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] instr;
  logic [31:0] pcPlus4;
  logic        valid;
  logic        halted;
  logic [31:0] pc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [31:0] NOP = 32'h00000000;
  localparam logic [31:0] WA  = 32'h11111111;
  localparam logic [31:0] WB  = 32'h22222222;
  localparam logic [31:0] WC  = 32'h33333333;
  localparam logic [31:0] WD  = 32'h44444444;
  localparam logic [31:0] W8  = 32'h08080808;
  localparam logic [31:0] W16 = 32'h16161616;
  localparam logic [31:0] WL  = 32'hABCD0255;
  localparam logic [31:0] HLT = 32'hFC000000;

  stage_if #(
    .RESET_PC   (32'h00000000),
    .IMEM_DEPTH (256)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .instr        (instr),
    .pcPlus4      (pcPlus4),
    .valid        (valid),
    .halted       (halted),
    .pc           (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_p4, input logic e_valid, input logic e_halted);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".instr"}, instr, e_instr);
    check({tag, ".pcPlus4"}, pcPlus4, e_p4);
    check({tag, ".valid"}, {31'b0, valid}, {31'b0, e_valid});
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halted});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
    for (int i = 0; i < 256; i++) dut.u_imem.mem[i] = 32'h00010000 + i;
    dut.u_imem.mem[0]   = WA;
    dut.u_imem.mem[1]   = WB;
    dut.u_imem.mem[2]   = WC;
    dut.u_imem.mem[3]   = WD;
    dut.u_imem.mem[8]   = W8;
    dut.u_imem.mem[16]  = W16;
    dut.u_imem.mem[255] = WL;
    @(negedge clock);

    // reset state
    do_reset();
    check_out("rst", 32'h0, NOP, 32'h0, 1'b0, 1'b0);

    // sequential fetch
    tick(); check_out("seq0", 32'h4,  WA, 32'h4,  1'b1, 1'b0);
    tick(); check_out("seq1", 32'h8,  WB, 32'h8,  1'b1, 1'b0);
    tick(); check_out("seq2", 32'hC,  WC, 32'hC,  1'b1, 1'b0);
    tick(); check_out("seq3", 32'h10, WD, 32'h10, 1'b1, 1'b0);

    // stall holds everything for 3 cycles
    do_reset();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_out("stall", 32'h8, WB, 32'h8, 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick(); check_out("unstall", 32'hC, WC, 32'hC, 1'b1, 1'b0);

    // branch with unaligned target, pcPlus4 holds
    do_reset();
    tick(); tick();
    branchTaken = 1'b1; branchTarget = 32'h00000043;
    tick(); check_out("br", 32'h40, NOP, 32'h8, 1'b0, 1'b0);
    branchTaken = 1'b0;
    tick(); check_out("br_next", 32'h44, W16, 32'h44, 1'b1, 1'b0);

    // branch during stall: stall ignored
    stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h20;
    tick(); check_out("br_stall", 32'h20, NOP, 32'h44, 1'b0, 1'b0);
    stall = 1'b0; branchTaken = 1'b0;
    tick(); check_out("br_stall_next", 32'h24, W8, 32'h24, 1'b1, 1'b0);

    // halt opcode fetched together with a branch is discarded
    dut.u_imem.mem[2] = HLT;
    do_reset();
    tick(); tick();
    branchTaken = 1'b1; branchTarget = 32'h10;
    tick(); check_out("halt_br", 32'h10, NOP, 32'h8, 1'b0, 1'b0);
    branchTaken = 1'b0;

    // halt entry and hold
    do_reset();
    tick(); tick();
    tick(); check_out("halt_in", 32'h8, HLT, 32'hC, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(); check_out("halt_hold", 32'h8, NOP, 32'hC, 1'b0, 1'b1);
    end
    branchTaken = 1'b1; branchTarget = 32'h0;
    tick(); check_out("halt_exit", 32'h0, NOP, 32'hC, 1'b0, 1'b0);
    branchTaken = 1'b0;
    tick(); check_out("resume", 32'h4, WA, 32'h4, 1'b1, 1'b0);

    // reset in HALTED with stall overrides everything
    tick(); tick(); check_out("rehalt", 32'h8, HLT, 32'hC, 1'b1, 1'b1);
    stall = 1'b1; reset = 1'b1;
    tick(); check_out("rst_halt", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; stall = 1'b0;
    tick(); check_out("rst_first", 32'h4, WA, 32'h4, 1'b1, 1'b0);
    dut.u_imem.mem[2] = WC;

    // index wrap modulo IMEM_DEPTH
    branchTaken = 1'b1; branchTarget = 32'h3FC;
    tick(); check_out("wrap_br", 32'h3FC, NOP, 32'h4, 1'b0, 1'b0);
    branchTaken = 1'b0;
    tick(); check_out("wrap_last", 32'h400, WL, 32'h400, 1'b1, 1'b0);
    tick(); check_out("wrap_first", 32'h404, WA, 32'h404, 1'b1, 1'b0);

    // 32-bit PC wrap
    branchTaken = 1'b1; branchTarget = 32'hFFFFFFFF;
    tick(); check_out("pc32_br", 32'hFFFFFFFC, NOP, 32'h404, 1'b0, 1'b0);
    branchTaken = 1'b0;
    tick(); check_out("pc32_wrap", 32'h0, WL, 32'h0, 1'b1, 1'b0);
    tick(); check_out("pc32_next", 32'h4, WA, 32'h4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
